dma_ext_port_ctrl: RTL and testbench

- External-port bus controller directly downstream of the DMA controller.
- Accepts single-word read/write requests (EPA address, EPD data) from the DMAC and runs them on the external memory bus with a cs/we/ack handshake and programmable wait states.
- Writes are posted through a small FIFO; reads are single-outstanding, ordered behind posted writes, and returned to the DMAC.
- Drives the DMAC's stall_ext input.

---
 rtl/dma_ext_port_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_dma_ext_port_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_ext_port_ctrl.sv
// External-port bus controller for the DMA controller.
// Single-word requests from the DMAC are run on the external memory bus with a
// cs/we/ack handshake and programmable wait states. Writes are posted through
// a small FIFO. Reads are single-outstanding, issue only after every earlier
// posted write has drained, and return their data to the DMAC.
// A bus cycle that sees no valid ack within TIMEOUT wait cycles is aborted and
// flagged on bus_err. A write is dropped on abort; a read returns all-ones.

module dma_ext_port_ctrl #(
    parameter int DW          = 16,
    parameter int AW          = 16,
    parameter int DEPTH       = 4,
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_wr,
    input  logic          req_rd,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          stall_ext,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          bus_err,
    output logic [AW-1:0] ext_addr,
    output logic [DW-1:0] ext_wdata,
    input  logic [DW-1:0] ext_rdata,
    output logic          ext_cs,
    output logic          ext_we,
    input  logic          ext_ack
);

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = PW - 1;
    // The wait counter has to be able to reach TIMEOUT-1.
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] WS_MIN   = CW'(WAIT_STATES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT,
        ST_HOLD
    } state_e;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_entry_t;

    // Posted-write FIFO
    wr_entry_t     fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    wr_entry_t     fifo_head;
    logic          fifo_empty;
    logic          fifo_full;

    // Request side
    logic          stall_init_q, stall_init_d;
    logic          rd_pending_q, rd_pending_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          push;
    logic          rd_accept;

    // Bus sequencer
    state_e        state_q, state_d;
    logic          cyc_write_q, cyc_write_d;
    logic          abort_q, abort_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          pop;
    logic          rd_done;

    // FIFO status and request acceptance
    always_comb begin
        fifo_head  = fifo_mem[rd_ptr_q[IW-1:0]];
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
        // Full blocks a push even if the head is popped on the same edge;
        // a simultaneous write wins over a read, which the DMAC keeps holding.
        stall_ext  = stall_init_q | fifo_full | rd_pending_q;
        push       = req_wr & ~stall_ext;
        rd_accept  = req_rd & ~req_wr & ~stall_ext;
    end

    // Next values for the FIFO pointers and the pending-read bookkeeping
    always_comb begin
        wr_ptr_d     = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d     = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        stall_init_d = 1'b0;
        rd_addr_d    = rd_accept ? req_addr : rd_addr_q;
        rd_pending_d = rd_pending_q;
        if (rd_accept) begin
            rd_pending_d = 1'b1;
        end else if (rd_done) begin
            rd_pending_d = 1'b0;
        end
    end

    // Bus FSM: next state and transfer bookkeeping
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no
        // path through the case can leave one unassigned and infer a latch.
        state_d     = state_q;
        cyc_write_d = cyc_write_q;
        abort_d     = abort_q;
        cnt_d       = cnt_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rd_data_d   = rd_data_q;
        pop         = 1'b0;
        rd_done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Posted writes always drain first, which is what keeps a read
                // ordered behind every write accepted before it.
                if (!fifo_empty) begin
                    state_d     = ST_SETUP;
                    cyc_write_d = 1'b1;
                    bus_addr_d  = fifo_head.addr;
                    bus_wdata_d = fifo_head.data;
                end else if (rd_pending_q) begin
                    state_d     = ST_SETUP;
                    cyc_write_d = 1'b0;
                    bus_addr_d  = rd_addr_q;
                    bus_wdata_d = '0;
                end
            end

            ST_SETUP: begin
                cnt_d   = '0;
                abort_d = 1'b0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (ext_ack && (cnt_q >= WS_MIN)) begin
                    state_d = ST_HOLD;
                    abort_d = 1'b0;
                    if (cyc_write_q) begin
                        pop = 1'b1;
                    end else begin
                        rd_data_d = ext_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // No usable ack in time: drop the write or return all-ones.
                    state_d = ST_HOLD;
                    abort_d = 1'b1;
                    if (cyc_write_q) begin
                        pop = 1'b1;
                    end else begin
                        rd_data_d = '1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_HOLD: begin
                // Turnaround cycle; a finished read is reported here and the
                // request port reopens on the next edge.
                rd_done = ~cyc_write_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus and DMAC-facing outputs, decoded from the registered state so that
    // an asynchronous reset drops the chip select at once.
    always_comb begin
        ext_cs    = (state_q == ST_SETUP) || (state_q == ST_WAIT);
        ext_we    = ext_cs & cyc_write_q;
        ext_addr  = bus_addr_q;
        ext_wdata = bus_wdata_q;
        rd_valid  = (state_q == ST_HOLD) & ~cyc_write_q;
        bus_err   = (state_q == ST_HOLD) & abort_q;
        rd_data   = rd_data_q;
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            stall_init_q <= 1'b1;
            rd_pending_q <= 1'b0;
            rd_addr_q    <= '0;
            cyc_write_q  <= 1'b0;
            abort_q      <= 1'b0;
            cnt_q        <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            stall_init_q <= stall_init_d;
            rd_pending_q <= rd_pending_d;
            rd_addr_q    <= rd_addr_d;
            cyc_write_q  <= cyc_write_d;
            abort_q      <= abort_d;
            cnt_q        <= cnt_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Posted-write entry storage, written on accepted writes
    always_ff @(posedge clk) begin
        // NOTE: the entry array has no reset; the pointers alone say which
        // entries are valid, so clearing the contents would achieve nothing.
        if (push) begin
            fifo_mem[wr_ptr_q[IW-1:0]] <= wr_entry_t'{addr: req_addr, data: req_wdata};
        end
    end

endmodule

// File: tb/tb_dma_ext_port_ctrl.sv
// Self-checking bench for dma_ext_port_ctrl.
// A transaction-level reference keeps the requests in acceptance order and
// follows each bus cycle by counting its chip-select cycles. From that it
// predicts stall_ext, the bus fields, completion, timeout aborts and
// read returns. Directed scenarios are followed by randomized traffic.

module tb_dma_ext_port_ctrl;

    localparam int DW      = 16;
    localparam int AW      = 16;
    localparam int DEPTH   = 4;
    localparam int WS      = 1;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_wr = 1'b0;
    logic          req_rd = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          stall_ext;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          bus_err;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic [DW-1:0] ext_rdata = '0;
    logic          ext_cs;
    logic          ext_we;
    logic          ext_ack = 1'b0;

    always #5 clk = ~clk;

    dma_ext_port_ctrl #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT_STATES(WS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_wr(req_wr), .req_rd(req_rd), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall_ext(stall_ext), .rd_valid(rd_valid), .rd_data(rd_data), .bus_err(bus_err),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
        .ext_cs(ext_cs), .ext_we(ext_we), .ext_ack(ext_ack)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    // Reference state
    txn_t          exp_q[$];     // accepted, not yet started on the bus
    txn_t          cur;          // transfer currently on the bus
    int            fifo_cnt;     // posted writes not yet finished on the bus
    logic          rd_pend;
    int            n_cs;         // chip-select cycles of the current transfer
    logic          start_next;
    logic          hold_exp, hold_rd, hold_abt;
    logic [DW-1:0] hold_data;
    logic          acc_last;

    // Independent observations
    int            cs_run, cs_len_obs, rdv_cnt, berr_cnt;

    // Stimulus knobs
    int            ack_mode;     // 0 low, 1 high, 2 random
    logic          rand_rdata;
    logic [DW-1:0] rdata_val;

    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        fifo_cnt   = 0;
        rd_pend    = 1'b0;
        n_cs       = 0;
        start_next = 1'b0;
        hold_exp   = 1'b0;
        hold_rd    = 1'b0;
        hold_abt   = 1'b0;
        hold_data  = '0;
        acc_last   = 1'b0;
        cs_run     = 0;
    endtask

    // Compare the outputs of the current cycle against the reference.
    task automatic monitor();
        logic exp_cs;
        check("stall_ext", 32'(stall_ext), 32'((fifo_cnt == DEPTH) || rd_pend));
        if (hold_exp)      exp_cs = 1'b0;
        else if (n_cs > 0) exp_cs = 1'b1;
        else               exp_cs = start_next;
        check("ext_cs", 32'(ext_cs), 32'(exp_cs));
        if (exp_cs) begin
            if (n_cs == 0) cur = exp_q.pop_front();
            n_cs++;
            check("ext_we", 32'(ext_we), 32'(cur.wr));
            check("ext_addr", 32'(ext_addr), 32'(cur.addr));
            if (cur.wr) check("ext_wdata", 32'(ext_wdata), 32'(cur.data));
        end else begin
            check("ext_we_idle", 32'(ext_we), 32'(1'b0));
        end
        check("rd_valid", 32'(rd_valid), 32'(hold_exp && hold_rd));
        check("bus_err", 32'(bus_err), 32'(hold_exp && hold_abt));
        if (hold_exp && hold_rd) check("rd_data", 32'(rd_data), 32'(hold_data));
        if (ext_cs) begin
            cs_run++;
        end else if (cs_run > 0) begin
            cs_len_obs = cs_run;
            cs_run     = 0;
        end
        if (rd_valid) rdv_cnt++;
        if (bus_err)  berr_cnt++;
    endtask

    task automatic finish_txn(input logic abort);
        hold_exp  = 1'b1;
        hold_rd   = ~cur.wr;
        hold_abt  = abort;
        hold_data = abort ? '1 : ext_rdata;
        if (cur.wr) fifo_cnt--;
        n_cs = 0;
    endtask

    // Advance the reference across the coming rising edge, given the inputs now driven.
    task automatic predict();
        logic stall_now;
        int   w;
        txn_t t;
        stall_now  = (fifo_cnt == DEPTH) || rd_pend;
        start_next = 1'b0;
        if (hold_exp) begin
            hold_exp = 1'b0;
            if (hold_rd) rd_pend = 1'b0;
        end else if (n_cs >= 2) begin
            // Cycle 1 of a transfer is the setup; wait cycles count from 0.
            w = n_cs - 2;
            if (ext_ack && (w >= WS))  finish_txn(1'b0);
            else if (w == TIMEOUT - 1) finish_txn(1'b1);
        end else if (n_cs == 0) begin
            start_next = (exp_q.size() != 0);
        end
        acc_last = 1'b0;
        if (!stall_now && req_wr) begin
            t.wr = 1'b1; t.addr = req_addr; t.data = req_wdata;
            exp_q.push_back(t);
            fifo_cnt++;
            acc_last = 1'b1;
        end else if (!stall_now && req_rd) begin
            t.wr = 1'b0; t.addr = req_addr; t.data = '0;
            exp_q.push_back(t);
            rd_pend  = 1'b1;
            acc_last = 1'b1;
        end
    endtask

    task automatic step(input logic wr, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        monitor();
        req_wr    = wr;
        req_rd    = rd;
        req_addr  = a;
        req_wdata = d;
        case (ack_mode)
            0:       ext_ack = 1'b0;
            1:       ext_ack = 1'b1;
            default: ext_ack = ($urandom_range(0, 9) < 4);
        endcase
        ext_rdata = rand_rdata ? DW'($urandom) : rdata_val;
        predict();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, '0, '0);
    endtask

    task automatic issue_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int tries = 0;
        step(1'b1, 1'b0, a, d);
        while (!acc_last && tries < 300) begin
            step(1'b1, 1'b0, a, d);
            tries++;
        end
        check("issue_wr_accepted", 32'(acc_last), 32'(1'b1));
    endtask

    task automatic issue_rd(input logic [AW-1:0] a);
        int tries = 0;
        step(1'b0, 1'b1, a, '0);
        while (!acc_last && tries < 300) begin
            step(1'b0, 1'b1, a, '0);
            tries++;
        end
        check("issue_rd_accepted", 32'(acc_last), 32'(1'b1));
    endtask

    task automatic apply_reset();
        req_wr  = 1'b0;
        req_rd  = 1'b0;
        ext_ack = 1'b0;
        rst     = 1'b0;
        #1;
        check("rst_cs", 32'(ext_cs), 32'(1'b0));
        check("rst_stall", 32'(stall_ext), 32'(1'b1));
        check("rst_rd_valid", 32'(rd_valid), 32'(1'b0));
        check("rst_bus_err", 32'(bus_err), 32'(1'b0));
        repeat (2) @(negedge clk);
        check("rst_we", 32'(ext_we), 32'(1'b0));
        check("rst_addr", 32'(ext_addr), 32'(0));
        check("rst_rd_data", 32'(rd_data), 32'(0));
        rst = 1'b1;
        #1;
        check("release_stall", 32'(stall_ext), 32'(1'b1));
        model_reset();
    endtask

    initial begin
        int rdv0, berr0, tries;
        logic wr, rd;

        rdv_cnt    = 0;
        berr_cnt   = 0;
        cs_len_obs = 0;
        ack_mode   = 1;
        rand_rdata = 1'b0;
        rdata_val  = 16'h5A5A;
        model_reset();
        #2;
        apply_reset();

        // Single write with ack tied high: setup plus two wait cycles.
        ack_mode = 1;
        issue_wr(16'h0010, 16'h1234);
        idle(8);
        check("t1_cs_len", 32'(cs_len_obs), 32'(WS + 2));

        // Fill the FIFO with ack low; the 5th write waits for the first pop (timeout).
        ack_mode = 0;
        berr0 = berr_cnt;
        for (int i = 0; i < 5; i++) issue_wr(16'h0100 + 16'(i), 16'hC000 + 16'(i));
        check("t2_first_aborted", 32'(berr_cnt - berr0), 32'(1));
        ack_mode = 1;
        idle(40);
        check("t2_one_abort_only", 32'(berr_cnt - berr0), 32'(1));

        // Write then read: the read follows the write on the bus.
        rdv0 = rdv_cnt;
        rdata_val = 16'h5A5A;
        step(1'b1, 1'b0, 16'h0020, 16'hAAAA);
        issue_rd(16'h0030);
        idle(12);
        check("t3_rd_valid_once", 32'(rdv_cnt - rdv0), 32'(1));
        check("t3_rd_data", 32'(rd_data), 32'(16'h5A5A));

        // Read that never gets an ack: abort after TIMEOUT wait cycles.
        ack_mode = 0;
        rdv0  = rdv_cnt;
        berr0 = berr_cnt;
        issue_rd(16'h0040);
        idle(TIMEOUT + 10);
        check("t5_cs_len", 32'(cs_len_obs), 32'(TIMEOUT + 1));
        check("t5_bus_err", 32'(berr_cnt - berr0), 32'(1));
        check("t5_rd_valid", 32'(rdv_cnt - rdv0), 32'(1));
        check("t5_rd_data", 32'(rd_data), 32'(16'hFFFF));

        // Write and read together: the write wins, the held read follows.
        ack_mode = 1;
        rdata_val = 16'h3C3C;
        rdv0 = rdv_cnt;
        step(1'b1, 1'b1, 16'h0050, 16'h1111);
        issue_rd(16'h0060);
        idle(14);
        check("t6_rd_valid", 32'(rdv_cnt - rdv0), 32'(1));
        check("t6_rd_data", 32'(rd_data), 32'(16'h3C3C));

        // Reset in the middle of a wait phase with writes still posted.
        ack_mode = 0;
        issue_wr(16'h0070, 16'h7070);
        issue_wr(16'h0071, 16'h7171);
        issue_wr(16'h0072, 16'h7272);
        tries = 0;
        while (n_cs < 3 && tries < 100) begin
            idle(1);
            tries++;
        end
        #2;
        check("t7_cs_before_reset", 32'(ext_cs), 32'(1'b1));
        rdv0  = rdv_cnt;
        berr0 = berr_cnt;
        apply_reset();
        ack_mode = 1;
        idle(12);
        check("t7_no_rd_valid", 32'(rdv_cnt - rdv0), 32'(0));
        check("t7_no_bus_err", 32'(berr_cnt - berr0), 32'(0));

        // Randomized traffic against the reference.
        ack_mode   = 2;
        rand_rdata = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            wr = ($urandom_range(0, 99) < 30);
            rd = ($urandom_range(0, 99) < 15);
            step(wr, rd, AW'($urandom), DW'($urandom));
        end
        idle(150);
        check("final_stall", 32'(stall_ext), 32'(1'b0));
        check("final_cs", 32'(ext_cs), 32'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
